// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: FIFO-buffered {A,D} frames sent MSB first with a gated forwarded clock.
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit after the data field.
module serial_frame_tx #(
  parameter int unsigned A_W   = 7,
  parameter int unsigned D_W   = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV   = 2
) (
  input  logic                       clk_in,
  input  logic                       reset_n,
  input  logic [A_W-1:0]             a_in,
  input  logic [D_W-1:0]             d_in,
  input  logic                       go,
  output logic                       ready,
  output logic                       out_d,
  output logic                       out_oe,
  output logic                       out_c,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int unsigned P_W = 1;
`else
  localparam int unsigned P_W = 0;
`endif
  localparam int unsigned FRAME_LEN = A_W + D_W + 4 + P_W;
  localparam int unsigned GAP0      = A_W + 1;
  localparam int unsigned GAP1      = FRAME_LEN - 2;
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned BIT_W     = $clog2(FRAME_LEN);
  localparam int unsigned PH_W      = $clog2(DIV);
  localparam int unsigned HALF      = DIV / 2;

  typedef enum logic [1:0] {IDLE, POP, SEND, GUARD} state_t;

  state_t               state;
  logic [A_W-1:0]       mem_a [DEPTH];
  logic [D_W-1:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [FRAME_LEN-1:0] shreg;
  logic [BIT_W-1:0]     bit_idx;
  logic [PH_W-1:0]      ph;

  logic                 push_c;
  logic                 pop_c;
  logic                 active_nxt_c;
  logic                 ph_last_c;
  logic                 bit_last_c;
  logic [CNT_W-1:0]     count_nxt_c;
  logic [PH_W-1:0]      ph_nxt_c;
  logic [BIT_W-1:0]     bit_nxt_c;
  logic [FRAME_LEN-1:0] frame_c;

  // FIFO occupancy, counters and whether the FSM stays out of IDLE next cycle
  always_comb begin
    push_c      = go && ready;
    pop_c       = (state == POP);
    count_nxt_c = count;
    if (push_c && !pop_c) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_nxt_c = count - CNT_W'(1);
    end
    ph_last_c  = (ph == PH_W'(DIV - 1));
    bit_last_c = (bit_idx == BIT_W'(FRAME_LEN - 1));
    ph_nxt_c   = ph + PH_W'(1);
    bit_nxt_c  = bit_idx + BIT_W'(1);
    case (state)
      IDLE:    active_nxt_c = (count != '0);
      GUARD:   active_nxt_c = !ph_last_c;
      default: active_nxt_c = 1'b1;
    endcase
  end

  // Whole frame in line order, first bit at the MSB; gap bits are carried as 1
  always_comb begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
    frame_c = {1'b0, mem_a[rd_ptr], 1'b1, mem_d[rd_ptr],
               ^{mem_a[rd_ptr], mem_d[rd_ptr]}, 1'b1, 1'b0};
`else
    frame_c = {1'b0, mem_a[rd_ptr], 1'b1, mem_d[rd_ptr], 1'b1, 1'b0};
`endif
  end

  always_ff @(posedge clk_in) begin
    if (push_c) begin
      mem_a[wr_ptr] <= a_in;
      mem_d[wr_ptr] <= d_in;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      ph         <= '0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      fifo_level <= '0;
      out_d      <= 1'b1;
      out_oe     <= 1'b1;
      out_c      <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_nxt_c;
      fifo_level <= count_nxt_c;
      ready      <= (count_nxt_c < CNT_W'(DEPTH));
      busy       <= active_nxt_c || (count_nxt_c != '0);
      case (state)
        IDLE: begin
          if (count != '0) state <= POP;
        end
        POP: begin
          state   <= SEND;
          shreg   <= {frame_c[FRAME_LEN-2:0], 1'b0};
          bit_idx <= '0;
          ph      <= '0;
          out_d   <= frame_c[FRAME_LEN-1];
          out_oe  <= 1'b1;
          out_c   <= 1'b0;
        end
        SEND: begin
          if (!ph_last_c) begin
            ph    <= ph_nxt_c;
            out_c <= (ph_nxt_c >= PH_W'(HALF));
          end else begin
            ph <= '0;
            if (bit_last_c) begin
              state  <= GUARD;
              out_d  <= 1'b1;
              out_oe <= 1'b1;
              out_c  <= 1'b1;
            end else begin
              bit_idx <= bit_nxt_c;
              shreg   <= {shreg[FRAME_LEN-2:0], 1'b0};
              out_d   <= shreg[FRAME_LEN-1];
              out_oe  <= !((bit_nxt_c == BIT_W'(GAP0)) || (bit_nxt_c == BIT_W'(GAP1)));
              out_c   <= 1'b0;
            end
          end
        end
        GUARD: begin
          if (ph_last_c) begin
            state <= IDLE;
            ph    <= '0;
          end else begin
            ph <= ph_nxt_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (DIV=2, DIV=4) checked every cycle against a timeline model.
module tb_serial_frame_tx;
  localparam int A_W   = 7;
  localparam int D_W   = 8;
  localparam int DEPTH = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int LEN = A_W + D_W + 5;
`else
  localparam int LEN = A_W + D_W + 4;
`endif
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int NPEND = 4096;

  logic             clk_in;
  logic             reset_n;
  logic             go;
  logic [A_W-1:0]   a_in;
  logic [D_W-1:0]   d_in;
  logic             rdy [2];
  logic             od  [2];
  logic             ooe [2];
  logic             oc  [2];
  logic             bsy [2];
  logic [LVL_W-1:0] lvl [2];

  serial_frame_tx #(.A_W(A_W), .D_W(D_W), .DEPTH(DEPTH), .DIV(2)) u_dut2 (
    .clk_in(clk_in), .reset_n(reset_n), .a_in(a_in), .d_in(d_in), .go(go),
    .ready(rdy[0]), .out_d(od[0]), .out_oe(ooe[0]), .out_c(oc[0]),
    .busy(bsy[0]), .fifo_level(lvl[0]));

  serial_frame_tx #(.A_W(A_W), .D_W(D_W), .DEPTH(DEPTH), .DIV(4)) u_dut4 (
    .clk_in(clk_in), .reset_n(reset_n), .a_in(a_in), .d_in(d_in), .go(go),
    .ready(rdy[1]), .out_d(od[1]), .out_oe(ooe[1]), .out_c(oc[1]),
    .busy(bsy[1]), .fifo_level(lvl[1]));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int     n_cmp;
  int     n_bad;
  int     tally [2];
  longint cyc;

  // Model: pending frames as a growing list, plus the frame currently on the line
  logic [A_W-1:0] pa [2][NPEND];
  logic [D_W-1:0] pd [2][NPEND];
  longint         pe [2][NPEND];
  int             hd [2];
  int             tl [2];
  longint         next_free [2];
  longint         cur_start [2];
  bit             cur_valid [2];
  logic [LEN-1:0] cur_bits  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int j);
    return (j == 0) ? 2 : 4;
  endfunction

  // Line bit b of a frame is returned at index LEN-1-b
  function automatic logic [LEN-1:0] frame_bits(input logic [A_W-1:0] a, input logic [D_W-1:0] d);
    logic [LEN-1:0] f;
    int b;
    f = '0;
    b = 0;
    f[LEN-1-b] = 1'b0; b++;
    for (int i = A_W - 1; i >= 0; i--) begin f[LEN-1-b] = a[i]; b++; end
    f[LEN-1-b] = 1'b1; b++;
    for (int i = D_W - 1; i >= 0; i--) begin f[LEN-1-b] = d[i]; b++; end
`ifdef SERIAL_FRAME_TX_PARITY_EN
    f[LEN-1-b] = ^{a, d}; b++;
`endif
    f[LEN-1-b] = 1'b1; b++;
    f[LEN-1-b] = 1'b0;
    return f;
  endfunction

  function automatic bit is_gap(input int b);
    return (b == A_W + 1) || (b == LEN - 2);
  endfunction

  function automatic void model_reset(input int j);
    hd[j] = 0;
    tl[j] = 0;
    next_free[j] = 0;
    cur_valid[j] = 1'b0;
  endfunction

  // A frame goes on the line two edges after it was queued, but no sooner than
  // two edges after the previous frame's guard bit ends.
  function automatic void model_step(input int j, input logic g,
                                     input logic [A_W-1:0] a, input logic [D_W-1:0] d);
    int sz;
    longint s;
    longint dv;
    sz = tl[j] - hd[j];
    dv = longint'(div_of(j));
    if (sz > 0) begin
      s = pe[j][hd[j]] + 2;
      if (next_free[j] > s) s = next_free[j];
      if (s <= cyc) begin
        cur_bits[j]  = frame_bits(pa[j][hd[j]], pd[j][hd[j]]);
        cur_start[j] = cyc;
        cur_valid[j] = 1'b1;
        next_free[j] = cyc + longint'(LEN + 1) * dv + 2;
        hd[j]++;
      end
    end
    if (g && (sz < DEPTH) && (tl[j] < NPEND)) begin
      pa[j][tl[j]] = a;
      pd[j][tl[j]] = d;
      pe[j][tl[j]] = cyc;
      tl[j]++;
    end
  endfunction

  function automatic logic [5+LVL_W-1:0] expected(input int j);
    int sz;
    longint rel;
    longint dv;
    int b;
    int p;
    logic e_d, e_oe, e_c, e_busy;
    sz = tl[j] - hd[j];
    dv = longint'(div_of(j));
    e_d = 1'b1; e_oe = 1'b1; e_c = 1'b1; e_busy = (sz > 0);
    if (cur_valid[j]) begin
      rel = cyc - cur_start[j];
      if (rel < longint'(LEN) * dv) begin
        b    = int'(rel / dv);
        p    = int'(rel % dv);
        e_d  = cur_bits[j][LEN-1-b];
        e_oe = !is_gap(b);
        e_c  = (p >= int'(dv / 2));
      end
      if (rel < longint'(LEN + 1) * dv) e_busy = 1'b1;
    end
    return {(sz < DEPTH), e_d, e_oe, e_c, e_busy, LVL_W'(sz)};
  endfunction

  // Per-cycle compare of both instances against the model
  initial begin
    logic g_s;
    logic r_s;
    logic [A_W-1:0] a_s;
    logic [D_W-1:0] d_s;
    cyc = 0;
    for (int j = 0; j < 2; j++) model_reset(j);
    forever begin
      @(posedge clk_in);
      g_s = go; a_s = a_in; d_s = d_in; r_s = reset_n;
      #1;
      cyc++;
      for (int j = 0; j < 2; j++) begin
        if (!r_s) model_reset(j);
        else model_step(j, g_s, a_s, d_s);
        check($sformatf("dut%0d cyc%0d {rdy,d,oe,c,busy,lvl}", j, cyc),
              32'({rdy[j], od[j], ooe[j], oc[j], bsy[j], lvl[j]}), 32'(expected(j)));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    for (int j = 0; j < 2; j++) if (bsy[j]) tally[j]++;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while ((bsy[0] || bsy[1]) && (n < bound)) begin
      tick();
      n++;
    end
    check({name, "_idle_dut2"}, 32'(bsy[0]), 32'd0);
    check({name, "_idle_dut4"}, 32'(bsy[1]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pct;
    logic [LEN-1:0] f;
    n_cmp = 0; n_bad = 0;
    tally[0] = 0; tally[1] = 0;
    go = 1'b0; a_in = '0; d_in = '0; reset_n = 1'b0;

    // Hand-computed frames pin the model's bit ordering
    f = frame_bits(7'h55, 8'hA3);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    check("model_frame_55_A3", 32'(f), 32'(20'b01010101110100011010));
    f = frame_bits(7'h01, 8'h00);
    check("model_parity_01_00", 32'(f[2]), 32'd1);
    f = frame_bits(7'h03, 8'h00);
    check("model_parity_03_00", 32'(f[2]), 32'd0);
`else
    check("model_frame_55_A3", 32'(f), 32'(19'b0101010111010001110));
`endif

    repeat (3) @(negedge clk_in);
    reset_n = 1'b1;
    tick();
    check("reset_state_dut2", 32'({rdy[0], od[0], ooe[0], oc[0], bsy[0], lvl[0]}), 32'b11110000);
    check("reset_state_dut4", 32'({rdy[1], od[1], ooe[1], oc[1], bsy[1], lvl[1]}), 32'b11110000);

    // Single frame A=55 D=A3: latency, clock phases and gap timing
    tally[0] = 0; tally[1] = 0;
    @(negedge clk_in); go = 1'b1; a_in = 7'h55; d_in = 8'hA3;
    tick();
    check("t2_level_after_accept", 32'(lvl[0]), 32'd1);
    check("t2_busy_after_accept", 32'(bsy[0]), 32'd1);
    @(negedge clk_in); go = 1'b0;
    tick();
    check("t2_line_idle_pop", 32'({od[0], oc[0]}), 32'b11);
    tick();
    check("t2_start_lo_dut2", 32'({od[0], ooe[0], oc[0]}), 32'b010);
    check("t2_start_lo_dut4", 32'({od[1], ooe[1], oc[1]}), 32'b010);
    tick();
    check("t2_start_hi_dut2", 32'({od[0], ooe[0], oc[0]}), 32'b011);
    check("t2_start_lo2_dut4", 32'({od[1], ooe[1], oc[1]}), 32'b010);
    tick();
    check("t2_a6_dut2", 32'({od[0], ooe[0], oc[0]}), 32'b110);
    check("t2_start_hi_dut4", 32'({od[1], ooe[1], oc[1]}), 32'b011);
    tick();
    tick();
    check("t2_a6_dut4", 32'({od[1], ooe[1], oc[1]}), 32'b110);
    repeat (12) tick();
    check("t2_gap_lo_dut2", 32'({od[0], ooe[0], oc[0]}), 32'b100);
    tick();
    check("t2_gap_hi_dut2", 32'({od[0], ooe[0], oc[0]}), 32'b101);
    tick();
    check("t2_d7_dut2", 32'({od[0], ooe[0], oc[0]}), 32'b110);
    wait_idle("t2", 300);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    check("t2_busy_cycles_dut2", 32'(tally[0]), 32'd44);
    check("t2_busy_cycles_dut4", 32'(tally[1]), 32'd86);
`else
    check("t2_busy_cycles_dut2", 32'(tally[0]), 32'd42);
    check("t2_busy_cycles_dut4", 32'(tally[1]), 32'd82);
`endif

    // Six back-to-back requests, then full FIFO with a pop on the same edge as go
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      go = 1'b1;
      a_in = (i == 0) ? 7'h01 : (i == 1) ? 7'h03 : A_W'($urandom);
      d_in = (i < 2) ? 8'h00 : D_W'($urandom);
      tick();
      if (i == 4) begin
        check("t3_ready_full_dut2", 32'(rdy[0]), 32'd0);
        check("t3_ready_full_dut4", 32'(rdy[1]), 32'd0);
        check("t3_level_full", 32'(lvl[0]), 32'd4);
      end
      if (i == 5) check("t3_sixth_dropped", 32'(lvl[0]), 32'd4);
    end
    n = 0;
    while ((lvl[0] == LVL_W'(DEPTH)) && (n < 200)) begin
      @(negedge clk_in); a_in = A_W'($urandom); d_in = D_W'($urandom);
      tick();
      n++;
    end
    check("t4_level_after_pop", 32'(lvl[0]), 32'(DEPTH - 1));
    check("t4_ready_after_pop", 32'(rdy[0]), 32'd1);
    @(negedge clk_in); go = 1'b0;
    tick();
    wait_idle("t3", 3000);

    // Reset asserted mid-frame at bit 6
    @(negedge clk_in); go = 1'b1; a_in = A_W'($urandom); d_in = D_W'($urandom);
    @(negedge clk_in); go = 1'b0;
    n = 0;
    do begin tick(); n++; end while (od[0] && (n < 10));
    check("t1_start_seen", 32'(od[0]), 32'd0);
    repeat (12) tick();
    @(negedge clk_in); reset_n = 1'b0;
    #1;
    check("t1_async_reset_dut2", 32'({rdy[0], od[0], ooe[0], oc[0], bsy[0], lvl[0]}), 32'b11110000);
    check("t1_async_reset_dut4", 32'({rdy[1], od[1], ooe[1], oc[1], bsy[1], lvl[1]}), 32'b11110000);
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;

    // Randomised traffic with varying request density and one reset pulse
    pct = 15;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      if ((i % 250) == 0) pct = (((i / 250) % 3) == 0) ? 15 : (((i / 250) % 3) == 1) ? 50 : 95;
      go   = ($urandom_range(99) < pct);
      a_in = A_W'($urandom);
      d_in = D_W'($urandom);
      if (i == 2100) reset_n = 1'b0;
      if (i == 2103) reset_n = 1'b1;
    end
    @(negedge clk_in); go = 1'b0;
    tick();
    wait_idle("final", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
